// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 decryptor types, constants and helpers
package aes_pkg;

    localparam int AES_NR = 10;
    localparam int AES_W  = 128;

    typedef logic [AES_W-1:0] state_t;
    typedef logic [3:0]       round_idx_t;

    // Rounds NR and 0 bypass InvMixColumns; every round in between applies it.
    function automatic logic is_mix_round(round_idx_t r);
        return (r != 4'd0) && (r < 4'(AES_NR));
    endfunction

endpackage

// File: rtl/inv_add_round_key_if.sv
// rtl/inv_add_round_key_if.sv - state stream in/out bundle for the AddRoundKey stage
interface inv_add_round_key_if #(
    parameter int W = 128
);
    logic         in_valid;
    logic         in_ready;
    logic         in_first;
    logic [W-1:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_state;
    logic [3:0]   out_round;
    logic         out_mix_en;
    logic         out_last;

    modport slave (
        input  in_valid, in_first, in_state, out_ready,
        output in_ready, out_valid, out_state, out_round, out_mix_en, out_last
    );

    modport master (
        output in_valid, in_first, in_state, out_ready,
        input  in_ready, out_valid, out_state, out_round, out_mix_en, out_last
    );
endinterface

// File: rtl/round_key_store.sv
// rtl/round_key_store.sv - NR+1 round-key register file with loaded flags
module round_key_store
    import aes_pkg::*;
#(
    parameter int NR = AES_NR,
    parameter int W  = AES_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  round_idx_t   wr_idx,
    input  logic [W-1:0] wr_data,
    input  round_idx_t   rd_idx,
    output logic [W-1:0] rd_key,
    output logic [NR:0]  loaded
);

    logic [W-1:0] keys [NR+1];
    logic         wr_ok;

    assign wr_ok = wr_en && (wr_idx <= round_idx_t'(NR));

    // Key contents survive reset; only the loaded flags are cleared.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            keys[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            loaded <= '0;
        end else if (wr_ok) begin
            loaded[wr_idx] <= 1'b1;
        end
    end

    assign rd_key = keys[rd_idx];

endmodule

// File: rtl/inv_add_round_key.sv
// rtl/inv_add_round_key.sv - registered AddRoundKey stage sequencing rounds NR..0
module inv_add_round_key
    import aes_pkg::*;
#(
    parameter int NR = AES_NR,
    parameter int W  = AES_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_wr_en,
    input  logic [3:0]          key_wr_idx,
    input  logic [W-1:0]        key_wr_data,
    output logic [NR:0]         keys_loaded,
    inv_add_round_key_if.slave  s
);

    round_idx_t   rnd;
    round_idx_t   r;
    logic [W-1:0] rd_key;
    logic         accept;

    round_key_store #(.NR(NR), .W(W)) u_store (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (key_wr_en),
        .wr_idx  (key_wr_idx),
        .wr_data (key_wr_data),
        .rd_idx  (r),
        .rd_key  (rd_key),
        .loaded  (keys_loaded)
    );

    assign r        = s.in_first ? round_idx_t'(NR) : rnd;
    assign s.in_ready = !s.out_valid || s.out_ready;
    assign accept   = s.in_valid && s.in_ready;

    // The read port sees the pre-edge key, so a same-cycle write is not forwarded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s.out_valid  <= 1'b0;
            s.out_state  <= '0;
            s.out_round  <= '0;
            s.out_mix_en <= 1'b0;
            s.out_last   <= 1'b0;
            rnd          <= round_idx_t'(NR);
        end else if (accept) begin
            s.out_valid  <= 1'b1;
            s.out_state  <= s.in_state ^ rd_key;
            s.out_round  <= r;
            s.out_mix_en <= is_mix_round(r);
            s.out_last   <= (r == 4'd0);
            rnd          <= (r == 4'd0) ? round_idx_t'(NR) : r - 4'd1;
        end else if (s.out_ready) begin
            s.out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inv_add_round_key.sv
// tb/tb_inv_add_round_key.sv - randomized and directed bench against a block-position model
module tb_inv_add_round_key;

    localparam logic [127:0] C1_IN  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1_OUT = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [127:0] K0     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] ONES   = {128{1'b1}};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_wr_en = 1'b0;
    logic [3:0]   key_wr_idx = '0;
    logic [127:0] key_wr_data = '0;
    logic [10:0]  keys_loaded;

    always #5 clk = ~clk;

    inv_add_round_key_if #(.W(128)) bus ();

    inv_add_round_key dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_wr_en   (key_wr_en),
        .key_wr_idx  (key_wr_idx),
        .key_wr_data (key_wr_data),
        .keys_loaded (keys_loaded),
        .s           (bus)
    );

    int           n_checks = 0;
    int           n_fail = 0;
    logic [127:0] mkeys [11];
    logic [10:0]  mloaded = '0;
    logic         exp_valid = 1'b0;
    logic [127:0] exp_state = '0;
    int           exp_round = 0;
    logic         exp_mix = 1'b0;
    logic         exp_last = 1'b0;
    int           pos = 0;

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(logic v, logic f, logic [127:0] st, logic rdy);
        bus.in_valid  = v;
        bus.in_first  = f;
        bus.in_state  = st;
        bus.out_ready = rdy;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // pos counts beats already taken from the current block (0..10); round = 10 - pos.
    task automatic step();
        logic acc;
        int   r;
        @(posedge clk);
        if (!rst_n) begin
            exp_valid = 1'b0; exp_state = '0; exp_round = 0;
            exp_mix = 1'b0; exp_last = 1'b0; pos = 0; mloaded = '0;
        end else begin
            acc = bus.in_valid && (!exp_valid || bus.out_ready);
            if (acc) begin
                r = bus.in_first ? 10 : 10 - pos;
                exp_state = bus.in_state ^ mkeys[r];
                exp_round = r;
                exp_mix   = (r >= 1) && (r <= 9);
                exp_last  = (r == 0);
                exp_valid = 1'b1;
                pos = bus.in_first ? 1 : (pos + 1) % 11;
            end else if (bus.out_ready) begin
                exp_valid = 1'b0;
            end
            if (key_wr_en && key_wr_idx <= 4'd10) mloaded[key_wr_idx] = 1'b1;
        end
        if (key_wr_en && key_wr_idx <= 4'd10) mkeys[key_wr_idx] = key_wr_data;
        #1;
        check("out_valid", bus.out_valid, exp_valid);
        check("out_state", bus.out_state, exp_state);
        check("out_round", bus.out_round, exp_round);
        check("out_mix_en", bus.out_mix_en, exp_mix);
        check("out_last", bus.out_last, exp_last);
        check("in_ready", bus.in_ready, !exp_valid || bus.out_ready);
        check("keys_loaded", keys_loaded, mloaded);
    endtask

    initial begin
        drive(1'b0, 1'b0, '0, 1'b1);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        for (int i = 0; i <= 10; i++) begin
            key_wr_en   = 1'b1;
            key_wr_idx  = 4'(i);
            key_wr_data = (i == 10) ? C1_K10 : (i == 0) ? K0 : rand128();
            step();
        end
        key_wr_en = 1'b0;
        check("keys_all", keys_loaded, 11'h7ff);

        drive(1'b1, 1'b1, C1_IN, 1'b1);
        step();
        check("c1_state", bus.out_state, C1_OUT);
        check("c1_round", bus.out_round, 4'd10);
        check("c1_mix", bus.out_mix_en, 1'b0);
        check("c1_last", bus.out_last, 1'b0);

        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 1'b0, (k == 10) ? '0 : rand128(), 1'b1);
            step();
        end
        check("rd0_state", bus.out_state, K0);
        check("rd0_last", bus.out_last, 1'b1);
        check("rd0_round", bus.out_round, 4'd0);

        drive(1'b1, 1'b1, rand128(), 1'b1);
        step();
        drive(1'b1, 1'b0, rand128(), 1'b1);
        step();
        drive(1'b1, 1'b0, rand128(), 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_ready", bus.in_ready, 1'b0);
            check("bp_round", bus.out_round, 4'd9);
        end
        drive(1'b1, 1'b0, rand128(), 1'b1);
        step();
        check("bp_resume", bus.out_round, 4'd8);

        for (int k = 0; k < 12 && exp_round != 0; k++) begin
            drive(1'b1, 1'b0, rand128(), 1'b1);
            step();
        end
        check("reach_r0", bus.out_round, 4'd0);
        drive(1'b1, 1'b0, rand128(), 1'b1);
        step();
        check("wrap", bus.out_round, 4'd10);
        for (int k = 0; k < 12 && exp_round != 5; k++) begin
            drive(1'b1, 1'b0, rand128(), 1'b1);
            step();
        end
        check("reach_r5", bus.out_round, 4'd5);
        drive(1'b1, 1'b1, rand128(), 1'b1);
        step();
        check("resync", bus.out_round, 4'd10);

        drive(1'b1, 1'b1, '0, 1'b1);
        key_wr_en = 1'b1; key_wr_idx = 4'd10; key_wr_data = ONES;
        step();
        key_wr_en = 1'b0;
        check("coll_old", bus.out_state, C1_K10);
        drive(1'b1, 1'b1, '0, 1'b1);
        step();
        check("coll_new", bus.out_state, ONES);
        drive(1'b0, 1'b0, '0, 1'b1);
        key_wr_en = 1'b1; key_wr_idx = 4'd12; key_wr_data = rand128();
        step();
        key_wr_en = 1'b0;
        check("idx12_loaded", keys_loaded, 11'h7ff);
        for (int k = 0; k <= 10; k++) begin
            drive(1'b1, k == 0, '0, 1'b1);
            step();
        end

        for (int k = 0; k < 4; k++) begin
            drive(1'b1, k == 0, rand128(), 1'b1);
            step();
        end
        rst_n = 1'b0;
        drive(1'b1, 1'b0, rand128(), 1'b1);
        step();
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_loaded", keys_loaded, 11'h000);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, rand128(), 1'b1);
        step();
        check("rst_round", bus.out_round, 4'd10);

        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rand128(),
                  $urandom_range(0, 3) != 0);
            key_wr_en   = $urandom_range(0, 7) == 0;
            key_wr_idx  = 4'($urandom_range(0, 15));
            key_wr_data = rand128();
            step();
        end
        key_wr_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inv_add_round_key.md
Name: inv_add_round_key

Overview:
Registered AddRoundKey stage for the AES-128 decryptor. It sits directly upstream of InvMixColumns in the inverse round datapath.
- Holds the 11 round keys, written once by the key-expansion logic.
- Sequences rounds 10 down to 0 per block and XORs each incoming state with the matching key.
- Tags each output with the round number and whether InvMixColumns must be applied.
- Uses a valid/ready handshake on both sides, with a single pipeline register.

Parameters:
NR, 10, number of rounds; NR+1 round keys stored.
W, 128, state and key width in bits.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  synchronous active-low reset.
key_wr_en  in  1  round-key write strobe.
key_wr_idx  in  4  round-key index, 0..NR; indices > NR are ignored.
key_wr_data  in  W  round key, byte 0 in [127:120].
keys_loaded  out  NR+1  bit i set once key i has been written.
in_valid  in  1  input state valid.
in_ready  out  1  stage can accept a beat.
in_first  in  1  beat is the first of a block; forces round = NR.
in_state  in  W  state from InvSubBytes (or ciphertext when round = NR).
out_valid  out  1  output beat valid.
out_ready  in  1  downstream accepts.
out_state  out  W  in_state XOR round key.
out_round  out  4  round number used for this beat.
out_mix_en  out  1  1 when 1 <= out_round <= NR-1; InvMixColumns is applied, otherwise bypassed.
out_last  out  1  1 when out_round = 0; block complete.

Behaviour:
- Reset (rst_n = 0 at a clk edge): out_valid=0, out_state=0, out_round=0, out_mix_en=0, out_last=0, keys_loaded=0, round counter=NR. Key storage is not cleared. Reset mid-block aborts the block: the next accepted beat uses round NR regardless of in_first.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - A beat is accepted when in_valid && in_ready.
  - A beat is transferred out when out_valid && out_ready.
  - out_* stay stable while out_valid && !out_ready.
  - in_valid may drop without penalty; no combinational path from in_valid to in_ready.
- Latency: 1 cycle from acceptance to out_valid. Full throughput, one beat per cycle, under continuous out_ready.
- Round counter rnd:
  - Effective round r = NR if in_first, else rnd.
  - On acceptance: out_state <= in_state ^ key[r]; out_round <= r; out_mix_en <= (r != 0 && r != NR); out_last <= (r == 0); rnd <= (r == 0) ? NR : r-1.
  - rnd wraps NR..0..NR, so back-to-back blocks need no in_first. in_first resynchronises mid-block and restarts at NR.
- Key storage: 11 x W registers.
  - A write takes effect at the clk edge. A beat accepted in the same cycle as a write to the same index uses the old key.
  - keys_loaded[i] is sticky until reset.
  - Beats are processed even if keys_loaded is incomplete; gating is the controller's job.
- Simultaneous acceptance and output transfer is the normal pipelined case; the register reloads.
- Output register with out_valid=1 and out_ready=0: no acceptance, and rnd holds.
- Width rules: out_round and rnd are 4 bits; values 11..15 never occur.

Decomposition:
- Shared package aes_pkg:
  - AES_NR=10, AES_W=128.
  - state_t (logic [127:0]).
  - round_idx_t (logic [3:0]).
  - function is_mix_round(round_idx_t).
- One natural sub-module, round_key_store: 11 x 128 register file with write port, combinational read port and keys_loaded. The rest (counter, XOR, output register) stays in the top.

Test Plan:
1. FIPS-197 C.1 vector.
   - Stimulus: load keys; present in_first=1, in_state=69c4e0d86a7b0430d8cdb78070b4c55a; key10=13111d7fe3944a17f307a78b4d2b30c5.
   - Response: one cycle later, out_state=7ad5fda789ef4e272bca100b3d9ff59f, out_round=10, out_mix_en=0, out_last=0.
2. Full block sequencing.
   - Stimulus: 11 consecutive beats with out_ready=1.
   - Response: out_round runs 10,9,...,0; out_mix_en=1 exactly for rounds 9..1; out_last=1 only on round 0. Round 0 with key0=000102030405060708090a0b0c0d0e0f and in_state=0 gives out_state=key0.
3. Back-pressure.
   - Stimulus: hold out_ready=0 for 3 cycles while in_valid=1.
   - Response: in_ready=0; out_* stable; rnd frozen. After release, out_round continues without skip or duplicate.
4. Wrap and resync.
   - After round 0, the next beat without in_first gets round 10.
   - in_first asserted at round 5 forces out_round=10.
5. Key write collision.
   - Stimulus: write key 10 = all-ones in the same cycle a round-10 beat with in_state=0 is accepted.
   - Response: out_state = old key10; the following round-10 beat yields all-ones. A write to idx 12 leaves storage and keys_loaded unchanged.
6. Reset mid-block.
   - Stimulus: rst_n=0 for one cycle at round 6.
   - Response: out_valid=0 and keys_loaded=0 next cycle; the next beat, with in_first=0, gets out_round=10.
